// File: rtl/driver_cell_pkg.sv
// Shared types, default sizes and the thermometer decode helper for the
// driver_cell slice controller.
package driver_cell_pkg;

   localparam int BIN_W   = 8;
   localparam int THERM_N = 17;
   localparam int MSB_W   = 5;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_WAKE  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } drv_state_e;

   // Bit i is set when i < m; codes above THERM_N clamp to all ones.
   function automatic logic [THERM_N-1:0] therm_decode(input logic [MSB_W-1:0] m);
      logic [THERM_N-1:0] t;
      t = '0;
      if (int'(m) > THERM_N) begin
         t = '1;
      end else begin
         for (int i = 0; i < THERM_N; i++) t[i] = (i < int'(m));
      end
      return t;
   endfunction

endpackage

// File: rtl/driver_cell_ctrl_therm_rotator.sv
// Barrel rotate-left of the thermometer lines by a pointer kept below N.
// Only used when DRIVER_CELL_CTRL_DEM_EN is defined.
module therm_rotator #(
   parameter int N     = 17,
   parameter int PTR_W = 5
) (
   input  logic [N-1:0]     i_therm,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N-1:0]     o_therm
);

   always_comb begin
      int sh;
      o_therm = '0;
      sh = int'(i_ptr) % N;
      for (int i = 0; i < N; i++) o_therm[i] = i_therm[(i + N - sh) % N];
   end

endmodule

// File: rtl/driver_cell_ctrl.sv
// Sequencing and code feed for one driver_cell DAC slice.
// Optional DWA element matching on the thermometer lines: DRIVER_CELL_CTRL_DEM_EN.
//
// state | meaning
// OFF   | pdb low, zero code, waiting for en
// WAKE  | pdb high, zero code, settle timer running
// RUN   | codes accepted over valid/ready
// DRAIN | pdb high, zero code, drain timer running before pdb falls
module driver_cell_ctrl #(
   parameter int BIN_W      = driver_cell_pkg::BIN_W,
   parameter int THERM_N    = driver_cell_pkg::THERM_N,
   parameter int MSB_W      = driver_cell_pkg::MSB_W,
   parameter int SETTLE_CYC = 16,
   parameter int DRAIN_CYC  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [MSB_W+BIN_W-1:0] code,
   input  logic                   code_valid,
   output logic                   code_ready,
   output logic                   pdb,
   output logic [BIN_W-1:0]       datain,
   output logic [BIN_W-1:0]       datainb,
   output logic [THERM_N-1:0]     datatherm,
   output logic [THERM_N-1:0]     datathermb,
   output logic                   sat,
   output logic [1:0]             state_o
);
   import driver_cell_pkg::*;

   localparam logic [1:0] S_OFF   = ST_OFF;
   localparam logic [1:0] S_WAKE  = ST_WAKE;
   localparam logic [1:0] S_RUN   = ST_RUN;
   localparam logic [1:0] S_DRAIN = ST_DRAIN;
   localparam int CNT_W = $clog2(SETTLE_CYC > DRAIN_CYC ? SETTLE_CYC : DRAIN_CYC) + 1;

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_pdb;
   logic [BIN_W-1:0]   r_datain;
   logic [BIN_W-1:0]   r_datainb;
   logic [THERM_N-1:0] r_therm;
   logic [THERM_N-1:0] r_thermb;
   logic               r_sat;

   logic [MSB_W-1:0]   w_msb;
   logic [BIN_W-1:0]   w_lsb;
   logic               w_sat;
   logic               w_accept;
   logic [BIN_W-1:0]   w_din_next;
   logic [THERM_N-1:0] w_therm_plain;
   logic [THERM_N-1:0] w_therm_next;

   assign w_msb         = code[BIN_W +: MSB_W];
   assign w_lsb         = code[BIN_W-1:0];
   assign w_sat         = w_msb > MSB_W'(THERM_N);
   assign code_ready    = (r_state == S_RUN) && en;
   assign w_accept      = code_ready && code_valid;
   assign w_din_next    = w_sat ? '1 : w_lsb;
   assign w_therm_plain = therm_decode(w_msb);

`ifdef DRIVER_CELL_CTRL_DEM_EN
   logic [MSB_W-1:0] r_ptr;
   logic [MSB_W-1:0] w_m_clamp;
   logic [MSB_W:0]   w_ptr_sum;
   logic [MSB_W-1:0] w_ptr_next;
   logic             w_enter_off;

   assign w_m_clamp   = w_sat ? MSB_W'(THERM_N) : w_msb;
   assign w_ptr_sum   = {1'b0, r_ptr} + {1'b0, w_m_clamp};
   assign w_ptr_next  = (w_ptr_sum >= (MSB_W+1)'(THERM_N)) ?
                        MSB_W'(w_ptr_sum - (MSB_W+1)'(THERM_N)) : MSB_W'(w_ptr_sum);
   assign w_enter_off = ((r_state == S_WAKE) && !en) ||
                        ((r_state == S_DRAIN) && (r_cnt == '0));

   therm_rotator #(.N(THERM_N), .PTR_W(MSB_W)) u_rot (
      .i_therm (w_therm_plain),
      .i_ptr   (r_ptr),
      .o_therm (w_therm_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             r_ptr <= '0;
      else if (r_state == S_OFF || w_enter_off) r_ptr <= '0;
      else if (w_accept)                      r_ptr <= w_ptr_next;
   end
`else
   assign w_therm_next = w_therm_plain;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_OFF;
         r_cnt     <= '0;
         r_pdb     <= 1'b0;
         r_datain  <= '0;
         r_datainb <= '1;
         r_therm   <= '0;
         r_thermb  <= '1;
         r_sat     <= 1'b0;
      end else begin
         r_sat <= 1'b0;
         case (r_state)
            S_OFF: begin
               r_pdb     <= 1'b0;
               r_datain  <= '0;
               r_datainb <= '1;
               r_therm   <= '0;
               r_thermb  <= '1;
               if (en) begin
                  r_state <= S_WAKE;
                  r_pdb   <= 1'b1;
                  r_cnt   <= CNT_W'(SETTLE_CYC - 1);
               end
            end
            S_WAKE: begin
               // outputs are already at zero code, so an abort skips the drain
               if (!en) begin
                  r_state <= S_OFF;
                  r_pdb   <= 1'b0;
               end else if (r_cnt == '0) begin
                  r_state <= S_RUN;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RUN: begin
               if (!en) begin
                  r_state   <= S_DRAIN;
                  r_cnt     <= CNT_W'(DRAIN_CYC - 1);
                  r_datain  <= '0;
                  r_datainb <= '1;
                  r_therm   <= '0;
                  r_thermb  <= '1;
               end else if (w_accept) begin
                  r_datain  <= w_din_next;
                  r_datainb <= ~w_din_next;
                  r_therm   <= w_therm_next;
                  r_thermb  <= ~w_therm_next;
                  r_sat     <= w_sat;
               end
            end
            default: begin
               if (r_cnt == '0) begin
                  r_state <= S_OFF;
                  r_pdb   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
         endcase
      end
   end

   assign pdb        = r_pdb;
   assign datain     = r_datain;
   assign datainb    = r_datainb;
   assign datatherm  = r_therm;
   assign datathermb = r_thermb;
   assign sat        = r_sat;
   assign state_o    = r_state;

endmodule

// File: tb/tb_driver_cell_ctrl.sv
// Self-checking bench for driver_cell_ctrl: directed power/decode sequences
// followed by randomized en/code traffic against a timestamp-based model.
module tb_driver_cell_ctrl;

   localparam int BIN_W   = 8;
   localparam int THERM_N = 17;
   localparam int MSB_W   = 5;
   localparam int SETTLE  = 16;
   localparam int DRAIN   = 4;
   localparam int TMASK   = (1 << THERM_N) - 1;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   en;
   logic [MSB_W+BIN_W-1:0] code;
   logic                   code_valid;
   logic                   code_ready;
   logic                   pdb;
   logic [BIN_W-1:0]       datain;
   logic [BIN_W-1:0]       datainb;
   logic [THERM_N-1:0]     datatherm;
   logic [THERM_N-1:0]     datathermb;
   logic                   sat;
   logic [1:0]             state_o;

   always #5 clk = ~clk;

   driver_cell_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .pdb        (pdb),
      .datain     (datain),
      .datainb    (datainb),
      .datatherm  (datatherm),
      .datathermb (datathermb),
      .sat        (sat),
      .state_o    (state_o)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Model: power state as timestamps of pdb rise and drain start.
   int k;
   bit m_pdb, m_drain;
   int m_tup, m_tdrain, m_p;
   int e_datain, e_therm;
   bit e_sat;

   function automatic int rotl(input int v, input int s);
      int r;
      r = s % THERM_N;
      return ((v << r) | (v >> (THERM_N - r))) & TMASK;
   endfunction

   function automatic int thermo(input int m);
      return (m >= THERM_N) ? TMASK : ((1 << m) - 1);
   endfunction

   function automatic bit running_before(input int edge_idx);
      return m_pdb && !m_drain && (edge_idx > m_tup + SETTLE);
   endfunction

   task automatic model_reset();
      m_pdb = 0; m_drain = 0; m_tup = 0; m_tdrain = 0; m_p = 0;
      e_datain = 0; e_therm = 0; e_sat = 0;
   endtask

   task automatic model_edge();
      bit run;
      int m, mc;
      k++;
      run   = running_before(k);
      e_sat = 0;
      if (!m_pdb) begin
         e_datain = 0; e_therm = 0; m_p = 0;
         if (en) begin m_pdb = 1; m_tup = k; end
      end else if (m_drain) begin
         if (k == m_tdrain + DRAIN) begin m_pdb = 0; m_drain = 0; m_p = 0; end
      end else if (!en) begin
         if (run) begin m_drain = 1; m_tdrain = k; end
         else begin m_pdb = 0; m_p = 0; end
         e_datain = 0; e_therm = 0;
      end else if (run && code_valid) begin
         m        = int'(code[BIN_W +: MSB_W]);
         mc       = (m > THERM_N) ? THERM_N : m;
         e_sat    = (m > THERM_N);
         e_datain = (m > THERM_N) ? 255 : int'(code[BIN_W-1:0]);
`ifdef DRIVER_CELL_CTRL_DEM_EN
         e_therm  = rotl(thermo(mc), m_p);
         m_p      = (m_p + mc) % THERM_N;
`else
         e_therm  = thermo(mc);
`endif
      end
   endtask

   function automatic int exp_state();
      if (!m_pdb) return 0;
      if (m_drain) return 3;
      if (k + 1 > m_tup + SETTLE) return 2;
      return 1;
   endfunction

   task automatic check_outputs();
      chk("pdb",        32'(pdb),        32'(m_pdb));
      chk("datain",     32'(datain),     32'(e_datain));
      chk("datainb",    32'(datainb),    32'(~e_datain & 255));
      chk("datatherm",  32'(datatherm),  32'(e_therm));
      chk("datathermb", 32'(datathermb), 32'(~e_therm & TMASK));
      chk("sat",        32'(sat),        32'(e_sat));
      chk("state_o",    32'(state_o),    32'(exp_state()));
   endtask

   // Called just after a negedge; applies inputs then checks the combinational ready.
   task automatic drive(input bit e, input bit v, input logic [MSB_W+BIN_W-1:0] c);
      en = e; code_valid = v; code = c;
      #1;
      chk("code_ready", 32'(code_ready), 32'(running_before(k + 1) && e));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_pdb",    32'(pdb),        32'h0);
      chk("rst_datain", 32'(datain),     32'h00);
      chk("rst_dinb",   32'(datainb),    32'hFF);
      chk("rst_therm",  32'(datatherm),  32'h0);
      chk("rst_thermb", 32'(datathermb), 32'h1FFFF);
      chk("rst_state",  32'(state_o),    32'h0);
      chk("rst_sat",    32'(sat),        32'h0);
      en = 1'b0; code_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int dstart;
      rst_n = 1'b0; en = 1'b0; code_valid = 1'b0; code = '0;
      k = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      async_reset();

      // power-up with offers during WAKE that must be refused
      drive(1, 0, '0); cycle();
      chk("pwr_pdb_rise", 32'(pdb), 32'h1);
      for (int i = 0; i < SETTLE; i++) begin
         drive(1, 1, {5'd9, 8'h55}); cycle();
      end
      drive(1, 1, {5'd5, 8'hAA}); cycle();
      chk("dec_datain", 32'(datain),     32'hAA);
      chk("dec_therm",  32'(datatherm),  32'h0001F);
      chk("dec_thermb", 32'(datathermb), 32'h1FFE0);
      drive(1, 1, {5'd3, 8'h10}); cycle();
`ifdef DRIVER_CELL_CTRL_DEM_EN
      chk("dem_rot", 32'(datatherm), 32'h000E0);
`else
      chk("dec_m3", 32'(datatherm), 32'h00007);
`endif
      drive(1, 1, {5'd20, 8'h03}); cycle();
      chk("sat_therm", 32'(datatherm), 32'h1FFFF);
      chk("sat_din",   32'(datain),    32'hFF);
      chk("sat_pulse", 32'(sat),       32'h1);
      drive(1, 0, '0); cycle();
      chk("sat_clear", 32'(sat), 32'h0);
      chk("hold_din",  32'(datain), 32'hFF);

      // power-down with a simultaneous offer, en pulsed inside DRAIN
      drive(0, 1, {5'd7, 8'h11}); cycle();
      chk("drn_zero", 32'(datatherm), 32'h0);
      dstart = k;
      drive(1, 0, '0); cycle();
      drive(0, 0, '0); cycle();
      drive(1, 0, '0); cycle();
      drive(1, 0, '0); cycle();
      chk("drn_pdb_off", 32'(pdb), 32'h0);
      chk("drn_len",     32'(k - dstart), 32'(DRAIN));
      drive(1, 0, '0); cycle();
      chk("rewake_pdb", 32'(pdb), 32'h1);

      // back to RUN, disturb the pointer, then reset mid-RUN
      for (int i = 0; i < SETTLE; i++) begin drive(1, 0, '0); cycle(); end
      drive(1, 1, {5'd11, 8'h3C}); cycle();
      drive(1, 1, {5'd4, 8'hC3}); cycle();
      async_reset();
      drive(1, 0, '0); cycle();
      for (int i = 0; i < SETTLE; i++) begin drive(1, 0, '0); cycle(); end
      drive(1, 1, {5'd5, 8'h01}); cycle();
      chk("ptr_after_rst", 32'(datatherm), 32'h0001F);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit e;
         e = en;
         if ($urandom_range(0, 59) == 0) e = ~e;
         if ($urandom_range(0, 699) == 0) async_reset();
         else begin
            drive(e, 1'($urandom_range(0, 1)), (MSB_W+BIN_W)'($urandom_range(0, 8191)));
            cycle();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
